// File: rtl/coder_pkg.sv
// Shared constants, state type and helpers for the turbo-coder block assembler.
// Provides K sizes, bytes-per-block counts and the fill FSM state enum.
package coder_pkg;

  localparam int K_LARGE      = 6144;
  localparam int K_SMALL      = 1056;
  localparam int NBYTES_LARGE = 768;
  localparam int NBYTES_SMALL = 132;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FULL
  } asm_state_e;

  // Index of the last byte of a block for the given K size.
  function automatic logic [9:0] last_idx(input logic k6144);
    return k6144 ? 10'(NBYTES_LARGE - 1)
                 : 10'(NBYTES_SMALL - 1);
  endfunction

endpackage

// File: rtl/blk_byte_writer.sv
// Computes the next block buffer after writing one byte lane (MSB-first).
// Ports: cur/nxt buffers, idx byte index, data byte, k6144 size, first flag.
module blk_byte_writer
  import coder_pkg::*;
#(
  parameter int KMAX   = K_LARGE,
  parameter int KMIN   = K_SMALL,
  parameter int DATA_W = 8
) (
  input  logic [KMAX-1:0]   cur,
  input  logic [9:0]        idx,
  input  logic [DATA_W-1:0] data,
  input  logic              k6144,
  input  logic              first,
  output logic [KMAX-1:0]   nxt
);

  logic [9:0]  lane;
  logic [12:0] base;

  always_comb begin
    // Lane counted from bit 0; byte 0 sits at the top of the K-bit field.
    lane = last_idx(k6144) - idx;
    base = 13'(lane) * 13'(DATA_W);
    nxt  = first ? '0 : cur;
    nxt[base +: DATA_W] = data;
    if (!k6144) begin
      nxt = nxt & {{(KMAX-KMIN){1'b0}}, {KMIN{1'b1}}};
    end
  end

endmodule

// File: rtl/byte_block_assembler.sv
// Packs a byte stream into a 6144/1056-bit code block for the interleaver.
// Ports: byte_in/byte_valid/byte_ready in, blk_out/blk_k_6144/blk_valid/
// blk_ready out, clear abort, byte_count status. Option: BYTE_ASSEMBLER_DOUBLE_BUF_EN.
module byte_block_assembler
  import coder_pkg::*;
#(
  parameter int KMAX   = K_LARGE,
  parameter int KMIN   = K_SMALL,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              k_sel,
  input  logic [DATA_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [KMAX-1:0]   blk_out,
  output logic              blk_k_6144,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [9:0]        byte_count
);

  logic       xfer;
  logic       wr_k;
  logic [9:0] cnt_q, cnt_n;
  asm_state_e st_q, st_n;

`ifdef BYTE_ASSEMBLER_DOUBLE_BUF_EN

  logic [1:0][KMAX-1:0] bank_q, bank_n, wr_blk;
  logic [1:0]           bk_q, bk_n;
  logic                 rd_q, rd_n;
  logic                 pv_q, pv_n;
  logic                 fi;
  logic                 acc;
  logic                 done;

  // Fill the presented bank while nothing is presented, else the shadow.
  assign fi         = pv_q ? ~rd_q : rd_q;
  assign byte_ready = (st_q != FULL);
  assign blk_valid  = pv_q;
  assign blk_out    = bank_q[rd_q];
  assign blk_k_6144 = bk_q[rd_q];
  assign byte_count = cnt_q;
  assign xfer       = byte_valid && byte_ready;
  assign acc        = pv_q && blk_ready;
  assign wr_k       = (st_q == IDLE) ? k_sel : bk_q[fi];
  assign done       = xfer && (st_q == FILL)
                   && (cnt_q == last_idx(bk_q[fi]));

  for (genvar g = 0; g < 2; g++) begin : g_wr
    blk_byte_writer #(
      .KMAX  (KMAX),
      .KMIN  (KMIN),
      .DATA_W(DATA_W)
    ) u_wr (
      .cur  (bank_q[g]),
      .idx  (cnt_q),
      .data (byte_in),
      .k6144(wr_k),
      .first(st_q == IDLE),
      .nxt  (wr_blk[g])
    );
  end

  always_comb begin
    st_n   = st_q;
    cnt_n  = cnt_q;
    bank_n = bank_q;
    bk_n   = bk_q;
    rd_n   = rd_q;
    pv_n   = pv_q;
    if (clear) begin
      st_n  = IDLE;
      cnt_n = '0;
      pv_n  = 1'b0;
    end else begin
      if (xfer) begin
        bank_n[fi] = wr_blk[fi];
        if (st_q == IDLE) begin
          bk_n[fi] = k_sel;
          cnt_n    = 10'd1;
          st_n     = FILL;
        end else begin
          cnt_n = cnt_q + 10'd1;
        end
      end
      if (done) begin
        if (!pv_q) begin
          pv_n  = 1'b1;
          st_n  = IDLE;
          cnt_n = '0;
        end else if (acc) begin
          rd_n  = fi;
          st_n  = IDLE;
          cnt_n = '0;
        end else begin
          st_n = FULL;
        end
      end else if (acc) begin
        if (st_q == FULL) begin
          rd_n  = fi;
          st_n  = IDLE;
          cnt_n = '0;
        end else begin
          pv_n = 1'b0;
          rd_n = ~rd_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      bank_q <= '0;
      bk_q   <= '0;
      rd_q   <= 1'b0;
      pv_q   <= 1'b0;
    end else begin
      st_q   <= st_n;
      cnt_q  <= cnt_n;
      bank_q <= bank_n;
      bk_q   <= bk_n;
      rd_q   <= rd_n;
      pv_q   <= pv_n;
    end
  end

`else

  logic [KMAX-1:0] blk_q, blk_n, wr_blk;
  logic            k_q, k_n;

  assign byte_ready = (st_q != FULL);
  assign blk_valid  = (st_q == FULL);
  assign blk_out    = blk_q;
  assign blk_k_6144 = k_q;
  assign byte_count = cnt_q;
  assign xfer       = byte_valid && byte_ready;
  // k_sel only matters on the first byte; afterwards the latched size rules.
  assign wr_k       = (st_q == IDLE) ? k_sel : k_q;

  blk_byte_writer #(
    .KMAX  (KMAX),
    .KMIN  (KMIN),
    .DATA_W(DATA_W)
  ) u_wr (
    .cur  (blk_q),
    .idx  (cnt_q),
    .data (byte_in),
    .k6144(wr_k),
    .first(st_q == IDLE),
    .nxt  (wr_blk)
  );

  always_comb begin
    st_n  = st_q;
    cnt_n = cnt_q;
    blk_n = blk_q;
    k_n   = k_q;
    if (clear) begin
      st_n  = IDLE;
      cnt_n = '0;
    end else begin
      case (st_q)
        IDLE: begin
          if (xfer) begin
            k_n   = k_sel;
            blk_n = wr_blk;
            cnt_n = 10'd1;
            st_n  = FILL;
          end
        end
        FILL: begin
          if (xfer) begin
            blk_n = wr_blk;
            cnt_n = cnt_q + 10'd1;
            if (cnt_q == last_idx(k_q)) begin
              st_n = FULL;
            end
          end
        end
        FULL: begin
          if (blk_ready) begin
            st_n  = IDLE;
            cnt_n = '0;
          end
        end
        default: begin
          st_n  = IDLE;
          cnt_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q  <= IDLE;
      cnt_q <= '0;
      blk_q <= '0;
      k_q   <= 1'b0;
    end else begin
      st_q  <= st_n;
      cnt_q <= cnt_n;
      blk_q <= blk_n;
      k_q   <= k_n;
    end
  end

`endif

endmodule
